// File: rtl/cdb_broadcaster_pkg.sv
// Shared widths and packet types for the CDB producer and its per-FU completion FIFOs.
package cdb_broadcaster_pkg;

   localparam int XLEN           = 32;
   localparam int ROB_LEN        = 32;
   localparam int TAG_W          = $clog2(ROB_LEN);
   localparam int NUM_FU_DEF     = 4;
   localparam int FIFO_DEPTH_DEF = 2;

   // ROB tag plus its qualifier; listeners only match when valid is set
   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             valid;
   } tag_packet_t;

   typedef struct packed {
      tag_packet_t     reg_tag;
      logic [XLEN-1:0] reg_value;
   } cdb_packet_t;

   // One buffered completion; tag.valid is stored as 1 so the head can be broadcast as-is
   typedef struct packed {
      tag_packet_t     tag;
      logic [XLEN-1:0] value;
   } fu_result_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// Completion FIFO for a single functional unit. Full refuses pushes even when
// a pop happens the same cycle; flush wins over push and pop.
module cdb_fu_fifo
   import cdb_broadcaster_pkg::*;
#(
   parameter  int DEPTH = FIFO_DEPTH_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  fu_result_t       data_in,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output fu_result_t       head,
   output logic [CNT_W-1:0] count
);

   fu_result_t       mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign head    = mem[head_ptr];

   // Storage array; contents are don't-care while empty, so no reset needed
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[tail_ptr] <= data_in;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (do_push) begin
            tail_ptr <= tail_ptr + 1'b1;
         end
         if (do_pop) begin
            head_ptr <= head_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common Data Bus producer: buffers completions per FU and broadcasts one
// registered result per cycle, chosen round-robin starting at rr_ptr.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter  int NUM_FU     = NUM_FU_DEF,
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int SEL_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    squash,
   input  logic [NUM_FU-1:0]       fu_valid,
   input  logic [NUM_FU*TAG_W-1:0] fu_tag,
   input  logic [NUM_FU*XLEN-1:0]  fu_value,
   output logic [NUM_FU-1:0]       fu_ready,
   output cdb_packet_t             cdb_packet_out,
   output logic [SEL_W-1:0]        cdb_fu_sel,
   output logic [NUM_FU*CNT_W-1:0] fifo_count
);

   fu_result_t       head_a [NUM_FU];
   logic [NUM_FU-1:0] empty_v;
   logic [NUM_FU-1:0] full_v;
   logic [NUM_FU-1:0] pop_v;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] rr_next;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_valid;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      fu_result_t       data_in;
      logic [CNT_W-1:0] count;

      assign data_in.tag.tag   = fu_tag[i*TAG_W +: TAG_W];
      assign data_in.tag.valid = 1'b1;
      assign data_in.value     = fu_value[i*XLEN +: XLEN];
      assign pop_v[i]          = grant_valid && (grant_idx == SEL_W'(i));
      assign fu_ready[i]       = !full_v[i];
      assign fifo_count[i*CNT_W +: CNT_W] = count;

      cdb_fu_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .push    (fu_valid[i]),
         .data_in (data_in),
         .pop     (pop_v[i]),
         .flush   (squash),
         .full    (full_v[i]),
         .empty   (empty_v[i]),
         .head    (head_a[i]),
         .count   (count)
      );
   end

   // Round-robin scan from rr_ptr; first non-empty FIFO wins
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % NUM_FU;
         if (!grant_valid && !empty_v[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(idx);
         end
      end
   end

   assign rr_next = (grant_idx == SEL_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

   // Bus register and arbiter pointer; squash drops the bus and restarts fairness at FU0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb_packet_out <= '0;
         cdb_fu_sel     <= '0;
         rr_ptr         <= '0;
      end else if (squash) begin
         cdb_packet_out <= '0;
         cdb_fu_sel     <= '0;
         rr_ptr         <= '0;
      end else if (grant_valid) begin
         cdb_packet_out.reg_tag   <= head_a[grant_idx].tag;
         cdb_packet_out.reg_value <= head_a[grant_idx].value;
         cdb_fu_sel               <= grant_idx;
         rr_ptr                   <= rr_next;
      end else begin
         cdb_packet_out <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: stimulus pushes expected broadcasts in
// order, a negedge monitor pops and compares whenever the bus is valid.
module tb_cdb_broadcaster;
   import cdb_broadcaster_pkg::*;

   localparam int NF = 4;
   localparam int CW = 2;
   localparam int SW = 2;
   localparam int K  = 6;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               squash = 1'b0;
   logic [NF-1:0]      fu_valid = '0;
   logic [NF*TAG_W-1:0] fu_tag = '0;
   logic [NF*XLEN-1:0] fu_value = '0;
   logic [NF-1:0]      fu_ready;
   cdb_packet_t        cdb_packet_out;
   logic [SW-1:0]      cdb_fu_sel;
   logic [NF*CW-1:0]   fifo_count;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  value;
      logic [SW-1:0]    sel;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   cdb_broadcaster dut (
      .clock          (clock),
      .reset          (reset),
      .squash         (squash),
      .fu_valid       (fu_valid),
      .fu_tag         (fu_tag),
      .fu_value       (fu_value),
      .fu_ready       (fu_ready),
      .cdb_packet_out (cdb_packet_out),
      .cdb_fu_sel     (cdb_fu_sel),
      .fifo_count     (fifo_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic set_fu(input int i, input int tag, input logic [XLEN-1:0] val);
      fu_valid[i] = 1'b1;
      fu_tag[i*TAG_W +: TAG_W] = TAG_W'(tag);
      fu_value[i*XLEN +: XLEN] = val;
   endtask

   task automatic expect_b(input int tag, input logic [XLEN-1:0] val, input int sel);
      exp_t e;
      e.tag   = TAG_W'(tag);
      e.value = val;
      e.sel   = SW'(sel);
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic int cnt(input int i);
      return int'(fifo_count[i*CW +: CW]);
   endfunction

   // Monitor: every valid bus cycle must match the next expected broadcast
   always @(negedge clock) begin
      if (reset && cdb_packet_out.reg_tag.valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bcast actual_tag=%0h actual_sel=%0d required=none",
                     cdb_packet_out.reg_tag.tag, cdb_fu_sel);
         end else begin
            mon_e = exp_q.pop_front();
            check("bcast_tag", cdb_packet_out.reg_tag.tag, mon_e.tag);
            check("bcast_value", cdb_packet_out.reg_value, mon_e.value);
            check("bcast_sel", cdb_fu_sel, mon_e.sel);
         end
      end
   end

   initial begin
      int p0, p1;
      logic a0, a1, saw_refuse0, saw_full0;

      // Reset state
      #12;
      check("rst_valid", cdb_packet_out.reg_tag.valid, 0);
      check("rst_packet", cdb_packet_out, 0);
      check("rst_sel", cdb_fu_sel, 0);
      check("rst_counts", fifo_count, 0);
      reset = 1'b1;
      @(negedge clock);
      check("rst_ready", fu_ready, 4'hF);

      // Single FU2 result, latency and one-cycle hold
      tick();
      set_fu(2, 5, 32'hDEAD_BEEF);
      expect_b(5, 32'hDEAD_BEEF, 2);
      tick();
      fu_valid = '0;
      @(negedge clock);
      check("t2_not_early", cdb_packet_out.reg_tag.valid, 0);
      @(negedge clock);
      check("t2_valid", cdb_packet_out.reg_tag.valid, 1);
      check("t2_sel", cdb_fu_sel, 2);
      @(negedge clock);
      check("t2_one_cycle", cdb_packet_out.reg_tag.valid, 0);

      // Reset mid-traffic; rr_ptr is 3 here so FU3 goes first
      tick();
      for (int i = 0; i < NF; i++) set_fu(i, 40 + i, 32'h4000_0000 + i);
      expect_b(43, 32'h4000_0003, 3);
      tick();
      fu_valid = '0;
      tick();
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("t1_async_valid", cdb_packet_out.reg_tag.valid, 0);
      check("t1_async_counts", fifo_count, 0);
      check("t1_async_sel", cdb_fu_sel, 0);
      #1;
      reset = 1'b1;
      #1;
      check("t1_ready_after", fu_ready, 4'hF);

      // All four push together from rr_ptr 0
      tick();
      for (int i = 0; i < NF; i++) begin
         set_fu(i, 1 + i, 32'hA000_0001 + i);
         expect_b(1 + i, 32'hA000_0001 + i, i);
      end
      tick();
      fu_valid = '0;
      repeat (6) tick();
      // rr_ptr back at 0: FU0 must beat FU3
      set_fu(0, 10, 32'h0000_0A0A);
      set_fu(3, 11, 32'h0000_0B0B);
      expect_b(10, 32'h0000_0A0A, 0);
      expect_b(11, 32'h0000_0B0B, 3);
      tick();
      fu_valid = '0;
      repeat (4) tick();

      // FU0 and FU1 contend continuously: strict alternation, FU0 back-pressured
      for (int j = 0; j < K; j++) begin
         expect_b(8 + j, 32'h0000_0800 + j, 0);
         expect_b(16 + j, 32'h0000_1600 + j, 1);
      end
      p0 = 0;
      p1 = 0;
      saw_refuse0 = 1'b0;
      saw_full0 = 1'b0;
      for (int cyc = 0; cyc < 60 && (p0 < K || p1 < K); cyc++) begin
         if (p0 < K) set_fu(0, 8 + p0, 32'h0000_0800 + p0);
         else fu_valid[0] = 1'b0;
         if (p1 < K) set_fu(1, 16 + p1, 32'h0000_1600 + p1);
         else fu_valid[1] = 1'b0;
         @(negedge clock);
         if (fu_valid[0] && !fu_ready[0]) saw_refuse0 = 1'b1;
         if (cnt(0) == 2) saw_full0 = 1'b1;
         a0 = fu_valid[0] && fu_ready[0];
         a1 = fu_valid[1] && fu_ready[1];
         tick();
         if (a0) p0++;
         if (a1) p1++;
      end
      fu_valid = '0;
      check("t4_all_pushed", p0 + p1, 2 * K);
      check("t4_fu0_refused", saw_refuse0, 1);
      check("t4_fu0_full", saw_full0, 1);
      repeat (8) tick();
      check("t4_drained", exp_q.size(), 0);

      // Squash with three results buffered and a FU3 push in the same cycle
      set_fu(0, 30, 32'h0000_3030);
      set_fu(1, 31, 32'h0000_3131);
      set_fu(2, 32, 32'h0000_3232);
      tick();
      fu_valid = '0;
      squash = 1'b1;
      set_fu(3, 7, 32'h0000_7777);
      @(negedge clock);
      check("t5_held3", cnt(0) + cnt(1) + cnt(2) + cnt(3), 3);
      tick();
      squash = 1'b0;
      fu_valid = '0;
      @(negedge clock);
      check("t5_valid", cdb_packet_out.reg_tag.valid, 0);
      check("t5_counts", fifo_count, 0);
      repeat (4) tick();
      set_fu(0, 12, 32'h0000_0C0C);
      set_fu(3, 13, 32'h0000_0D0D);
      expect_b(12, 32'h0000_0C0C, 0);
      expect_b(13, 32'h0000_0D0D, 3);
      tick();
      fu_valid = '0;
      repeat (4) tick();

      // FU2 at full rate: one broadcast per cycle, never back-pressured
      for (int j = 0; j < 8; j++) begin
         set_fu(2, 20 + j, 32'h0000_2000 + j);
         expect_b(20 + j, 32'h0000_2000 + j, 2);
         @(negedge clock);
         check("t6_ready", fu_ready[2], 1);
         if (j >= 2) check("t6_steady_valid", cdb_packet_out.reg_tag.valid, 1);
         tick();
      end
      fu_valid = '0;

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
      repeat (3) tick();
      check("final_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
